// File: rtl/exp2_pkg.sv
// Shared definitions for the Experiment 2 control unit.
// estado_t holds the 4-bit state encodings; db_estado shows these values directly,
// so they must not be renumbered.
package exp2_pkg;

  localparam int unsigned EstadoBits = 4;

  typedef enum logic [EstadoBits-1:0] {
    Inicial    = 4'd0,
    Prepara    = 4'd1,
    Espera     = 4'd2,
    Compara    = 4'd3,
    Proximo    = 4'd4,
    FimAcerto  = 4'd6,
    FimErro    = 4'd7,
    FimTimeout = 4'd8
  } estado_t;

  // Any end state.
  function automatic logic is_fim(estado_t e);
    return (e == FimAcerto) || (e == FimErro) || (e == FimTimeout);
  endfunction

endpackage

// File: rtl/unidade_controle_exp2_if.sv
// Signal bundle between the control unit and its environment (user inputs and datapath).
//   iniciar, jogada : user controls
//   igual, fim      : datapath status (comparator, counter rco)
//   zera, conta     : datapath controls
//   pronto, acertou, errou, timeout, db_estado : game status / debug
// master: environment side. slave: control unit side.
interface unidade_controle_exp2_if;

  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim;
  logic       zera;
  logic       conta;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, igual, fim,
    input  zera, conta, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, fim,
    output zera, conta, pronto, acertou, errou, timeout, db_estado
  );

endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector producing a registered one-cycle pulse.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   sinal   : level input
//   pulso   : high for one cycle, one clock after sinal is first seen high
// The pulse is registered, so the detector contributes one cycle of latency.
module edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;
  logic pulso_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sinal_q <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      sinal_q <= sinal;
      pulso_q <= sinal & ~sinal_q;
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/unidade_controle_exp2.sv
// Control unit for the Experiment 2 compare-with-counter datapath.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : unidade_controle_exp2_if.slave
//             (iniciar, jogada, igual, fim in; zera, conta, pronto, acertou,
//              errou, timeout, db_estado out)
// Parameter TIMEOUT_CICLOS: cycles allowed in Espera before a timeout (2..65535).
// Optional macro TIMEOUT_EN: builds the Espera cycle counter and the FimTimeout path.
// Without it, timeout is tied 0.
// Outputs are Moore, decoded from the state register only.
module unidade_controle_exp2
  import exp2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 100
) (
  input logic                    clock,
  input logic                    reset_n,
  unidade_controle_exp2_if.slave bus
);

  if ((TIMEOUT_CICLOS < 2) || (TIMEOUT_CICLOS > 65535)) begin : g_param_check
    $error("TIMEOUT_CICLOS out of range 2..65535");
  end

  estado_t estado_q, estado_d;
  logic    jogada_pulso;

  edge_detector u_edge_jogada (
    .clock   (clock),
    .reset_n (reset_n),
    .sinal   (bus.jogada),
    .pulso   (jogada_pulso)
  );

`ifdef TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CICLOS - 1);

  logic [15:0] espera_cnt_q;
  logic        expirou;

  // Held at 0 outside Espera, so it reads 0 on the first Espera cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      espera_cnt_q <= '0;
    end else if (estado_q != Espera) begin
      espera_cnt_q <= '0;
    end else begin
      espera_cnt_q <= espera_cnt_q + 16'd1;
    end
  end

  assign expirou = (espera_cnt_q == TimeoutLast);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= Inicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      Inicial: begin
        if (bus.iniciar) estado_d = Prepara;
      end
      Prepara: estado_d = Espera;
      Espera: begin
        // A pulse on the final timeout cycle still wins.
        if (jogada_pulso) begin
          estado_d = Compara;
        end
`ifdef TIMEOUT_EN
        else if (expirou) begin
          estado_d = FimTimeout;
        end
`endif
      end
      Compara: begin
        if (!bus.igual)   estado_d = FimErro;
        else if (bus.fim) estado_d = FimAcerto;
        else              estado_d = Proximo;
      end
      Proximo: estado_d = Espera;
      FimAcerto, FimErro, FimTimeout: begin
        if (bus.iniciar) estado_d = Prepara;
      end
      default: estado_d = Inicial;
    endcase
  end

  logic zera, conta, pronto, acertou, errou, timeout;

  always_comb begin
    zera    = (estado_q == Prepara);
    conta   = (estado_q == Proximo);
    pronto  = is_fim(estado_q);
    acertou = (estado_q == FimAcerto);
    errou   = (estado_q == FimErro) || (estado_q == FimTimeout);
`ifdef TIMEOUT_EN
    timeout = (estado_q == FimTimeout);
`else
    timeout = 1'b0;
`endif
  end

  assign bus.zera      = zera;
  assign bus.conta     = conta;
  assign bus.pronto    = pronto;
  assign bus.acertou   = acertou;
  assign bus.errou     = errou;
  assign bus.timeout   = timeout;
  assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp2.sv
module tb_unidade_controle_exp2;

`ifdef TIMEOUT_EN
  localparam int TO = 10;
  localparam int HOLD_LONG = 6;
`else
  localparam int TO = 100;
  localparam int HOLD_LONG = 20;
`endif

  localparam int K_ZERA = 0;
  localparam int K_CONTA = 1;
  localparam int K_FIM = 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  unidade_controle_exp2_if bus ();

  unidade_controle_exp2 #(.TIMEOUT_CICLOS(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Datapath stand-in: counter with synchronous clear/enable, comparator, rco.
  logic [3:0] chaves = 4'd0;
  logic [3:0] dp_count = 4'd9;
  always @(posedge clock) begin
    if (bus.zera) dp_count <= 4'd0;
    else if (bus.conta) dp_count <= dp_count + 4'd1;
  end
  assign bus.igual = (chaves == dp_count);
  assign bus.fim = (dp_count == 4'd15);

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] estado;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       tmo;
    logic [3:0] valor;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int conta_seen = 0;
  int model_cnt = 0;

  function automatic ev_t mk(int k, int e, bit p, bit a, bit er, bit t, int v);
    ev_t x;
    x.kind = 2'(k); x.estado = 4'(e); x.pronto = p; x.acertou = a;
    x.errou = er; x.tmo = t; x.valor = 4'(v);
    return x;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every zera/conta cycle and every rising edge of pronto is an event.
  logic pronto_prev = 1'b0;

  task automatic observe(input ev_t o);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: unexpected kind=%0d estado=%0d valor=%0d, required none",
               o.kind, o.estado, o.valor);
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        fails++;
        $display("FAIL event: got k=%0d st=%0d p=%0d a=%0d e=%0d t=%0d v=%0d, required k=%0d st=%0d p=%0d a=%0d e=%0d t=%0d v=%0d",
                 o.kind, o.estado, o.pronto, o.acertou, o.errou, o.tmo, o.valor,
                 e.kind, e.estado, e.pronto, e.acertou, e.errou, e.tmo, e.valor);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (bus.zera)
        observe(mk(K_ZERA, bus.db_estado, bus.pronto, bus.acertou, bus.errou, bus.timeout, 0));
      if (bus.conta) begin
        conta_seen++;
        observe(mk(K_CONTA, bus.db_estado, bus.pronto, bus.acertou, bus.errou, bus.timeout,
                   dp_count));
      end
      if (bus.pronto && !pronto_prev)
        observe(mk(K_FIM, bus.db_estado, bus.pronto, bus.acertou, bus.errou, bus.timeout, 0));
    end
    pronto_prev = bus.pronto;
  end

  task automatic wait_espera_or_fim(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.db_estado == 4'd2 || bus.pronto) && n < 30);
    if (n >= 30) check(name, int'(bus.db_estado), 2);
  endtask

  task automatic start_game(input bit check_seq);
    @(negedge clock);
    bus.iniciar = 1'b1;
    exp_q.push_back(mk(K_ZERA, 1, 0, 0, 0, 0, 0));
    @(negedge clock);
    bus.iniciar = 1'b0;
    model_cnt = 0;
    if (check_seq) check("start_prepara", int'(bus.db_estado), 1);
    @(negedge clock);
    if (check_seq) check("start_espera", int'(bus.db_estado), 2);
    if (bus.db_estado != 4'd2) wait_espera_or_fim("start_wait");
  endtask

  // One press; the reference model pushes what the game should do with this guess.
  task automatic press(input int v, input int hold, output bit alive);
    int n;
    repeat (1 + $urandom_range(0, 3)) @(negedge clock);
    chaves = 4'(v);
    bus.jogada = 1'b1;
    alive = 1'b0;
    if (v == model_cnt) begin
      if (model_cnt == 15) begin
        exp_q.push_back(mk(K_FIM, 6, 1, 1, 0, 0, 0));
      end else begin
        exp_q.push_back(mk(K_CONTA, 4, 0, 0, 0, 0, model_cnt));
        model_cnt++;
        alive = 1'b1;
      end
    end else begin
      exp_q.push_back(mk(K_FIM, 7, 1, 0, 1, 0, 0));
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.db_estado != 4'd3 && n < 10);
    check("press_latency", n, 2);
    if (hold > 2) repeat (hold - 2) @(negedge clock);
    bus.jogada = 1'b0;
    wait_espera_or_fim("press_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit alive;
    int c0;
    int v;
    reset_n = 1'b0;
    bus.iniciar = 1'b0;
    bus.jogada = 1'b0;
    #1;
    check("reset_estado", int'(bus.db_estado), 0);
    check("reset_outs", int'({bus.zera, bus.conta, bus.pronto, bus.acertou, bus.errou,
                              bus.timeout}), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_inicial", int'(bus.db_estado), 0);

    // Full win: 16 correct guesses, 15 conta pulses.
    start_game(1'b1);
    c0 = conta_seen;
    for (int i = 0; i < 16; i++) press(i, $urandom_range(2, 4), alive);
    check("win_contas", conta_seen - c0, 15);
    check("win_estado", int'(bus.db_estado), 6);
    check("win_flags", int'({bus.pronto, bus.acertou, bus.errou}), 3'b110);

    // Early mismatch at count 3.
    start_game(1'b0);
    for (int i = 0; i < 3; i++) press(i, 2, alive);
    c0 = conta_seen;
    press(5, 2, alive);
    repeat (5) @(negedge clock);
    check("err_estado", int'(bus.db_estado), 7);
    check("err_flags", int'({bus.pronto, bus.acertou, bus.errou}), 3'b101);
    check("err_no_conta", conta_seen - c0, 0);

    // Restart from FimErro, then a long-held button yields one conta.
    start_game(1'b1);
    c0 = conta_seen;
    press(0, HOLD_LONG, alive);
    repeat (3) @(negedge clock);
    check("held_one_conta", conta_seen - c0, 1);
    press(1, 2, alive);
    press(9, 3, alive);

    // Randomized games.
    for (int g = 0; g < 8; g++) begin
      start_game(1'b0);
      alive = 1'b1;
      while (alive) begin
        v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : model_cnt;
        press(v, $urandom_range(2, 5), alive);
      end
    end

    // Mid-game reset returns to Inicial at once.
    start_game(1'b0);
    press(0, 2, alive);
    press(1, 2, alive);
    check("pre_reset_queue", exp_q.size(), 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset_estado", int'(bus.db_estado), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("after_reset_idle", int'(bus.db_estado), 0);
    start_game(1'b0);
    press(0, 2, alive);
    press(3, 2, alive);

`ifdef TIMEOUT_EN
    // No press: FimTimeout exactly TO cycles after entering Espera.
    start_game(1'b0);
    exp_q.push_back(mk(K_FIM, 8, 1, 0, 1, 1, 0));
    c0 = 0;
    do begin
      @(negedge clock);
      c0++;
    end while (bus.db_estado != 4'd8 && c0 < 50);
    check("timeout_cycles", c0, TO);
    check("timeout_flag", int'(bus.timeout), 1);
`endif

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
